// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: bubble encoding, FSM states, register index width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] q2_rs1_i;
  logic [REG_IDX_W-1:0] q2_rs2_i;
  logic                 q2_use_rs1_i;
  logic                 q2_use_rs2_i;
  logic [REG_IDX_W-1:0] q3_rd_i;
  logic                 q3_mem_rd_i;
  logic                 q3_redirect_i;
  logic                 q4_mem_req_i;
  logic                 dmem_ready_i;
  logic                 pc_en_o;
  logic                 pc_sel_o;
  logic                 q1q2_en_o;
  logic                 q1q2_flush_o;
  logic                 q2q3_en_o;
  logic                 q2q3_flush_o;
  logic                 q3q4_en_o;
  logic                 q4q5_flush_o;
  logic                 err_o;

  modport master (
    output q2_rs1_i, q2_rs2_i, q2_use_rs1_i, q2_use_rs2_i, q3_rd_i, q3_mem_rd_i,
           q3_redirect_i, q4_mem_req_i, dmem_ready_i,
    input  pc_en_o, pc_sel_o, q1q2_en_o, q1q2_flush_o, q2q3_en_o, q2q3_flush_o,
           q3q4_en_o, q4q5_flush_o, err_o
  );

  modport slave (
    input  q2_rs1_i, q2_rs2_i, q2_use_rs1_i, q2_use_rs2_i, q3_rd_i, q3_mem_rd_i,
           q3_redirect_i, q4_mem_req_i, dmem_ready_i,
    output pc_en_o, pc_sel_o, q1q2_en_o, q1q2_flush_o, q2q3_en_o, q2q3_flush_o,
           q3q4_en_o, q4q5_flush_o, err_o
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Two independently enabled free-running wrap counters (stall cycles, redirect cycles).
module pipe_perf_cnt #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_inc,
  input  logic                 flush_inc,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, redirect squash, dmem wait freeze with sticky timeout.
// Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_ctrl_if.slave     hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              freeze;
  logic              redirect;
  logic              load_use;
  logic              lu_match;

  // rd==x0 can never create a true dependency
  assign lu_match = hz.q3_mem_rd_i && (hz.q3_rd_i != '0) &&
                    ((hz.q2_use_rs1_i && (hz.q2_rs1_i == hz.q3_rd_i)) ||
                     (hz.q2_use_rs2_i && (hz.q2_rs2_i == hz.q3_rd_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      hz.err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT)) hz.err_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    freeze          = 1'b0;
    hz.pc_en_o      = 1'b1;
    hz.pc_sel_o     = 1'b0;
    hz.q1q2_en_o    = 1'b1;
    hz.q1q2_flush_o = 1'b0;
    hz.q2q3_en_o    = 1'b1;
    hz.q2q3_flush_o = 1'b0;
    hz.q3q4_en_o    = 1'b1;
    hz.q4q5_flush_o = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.q4_mem_req_i && !hz.dmem_ready_i) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready_i) begin
          freeze = 1'b1;
          if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: state_nxt = RUN;
    endcase

    redirect = !freeze && hz.q3_redirect_i;
    load_use = !freeze && !hz.q3_redirect_i && lu_match;

    if (freeze) begin
      hz.pc_en_o      = 1'b0;
      hz.q1q2_en_o    = 1'b0;
      hz.q2q3_en_o    = 1'b0;
      hz.q3q4_en_o    = 1'b0;
      hz.q4q5_flush_o = 1'b1;
    end else if (redirect) begin
      hz.pc_sel_o     = 1'b1;
      hz.q1q2_flush_o = 1'b1;
      hz.q2q3_flush_o = 1'b1;
    end else if (load_use) begin
      hz.pc_en_o      = 1'b0;
      hz.q1q2_en_o    = 1'b0;
      hz.q2q3_flush_o = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  pipe_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_inc (!hz.pc_en_o),
    .flush_inc (redirect),
    .stall_cnt (stall_cnt_o),
    .flush_cnt (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus dmem-wait, timeout and perf sequences.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [7:0] O_RUN = 8'b1010_1010;
  localparam logic [7:0] O_RED = 8'b1111_1110;
  localparam logic [7:0] O_LU  = 8'b0000_1110;
  localparam logic [7:0] O_FRZ = 8'b0000_0001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t tbl[16];

  pipe_hazard_ctrl_if hz();

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));
`else
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
`endif

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic mrd,
                              input logic redir, input logic req, input logic rdy,
                              input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mrd = mrd; v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {hz.pc_en_o, hz.pc_sel_o, hz.q1q2_en_o, hz.q1q2_flush_o,
            hz.q2q3_en_o, hz.q2q3_flush_o, hz.q3q4_en_o, hz.q4q5_flush_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.q2_rs1_i      = v.rs1;
    hz.q2_rs2_i      = v.rs2;
    hz.q2_use_rs1_i  = v.u1;
    hz.q2_use_rs2_i  = v.u2;
    hz.q3_rd_i       = v.rd;
    hz.q3_mem_rd_i   = v.mrd;
    hz.q3_redirect_i = v.redir;
    hz.q4_mem_req_i  = v.req;
    hz.dmem_ready_i  = v.rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rs1  rs2  u1 u2 rd   mrd red req rdy exp
    tbl[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RUN);
    tbl[1]  = mk(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, O_LU);
    tbl[2]  = mk(5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, O_RUN);
    tbl[3]  = mk(5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, O_LU);
    tbl[4]  = mk(5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0, O_RUN);
    tbl[5]  = mk(5'd7, 5'd0, 1, 0, 5'd7, 0, 0, 0, 0, O_RUN);
    tbl[6]  = mk(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, O_RED);
    tbl[7]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RED);
    tbl[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_RUN);
    tbl[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, O_RUN);
    tbl[10] = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 1, O_LU);
    tbl[11] = mk(5'd31, 5'd0, 1, 0, 5'd30, 1, 0, 0, 0, O_RUN);
    tbl[12] = mk(5'd31, 5'd31, 1, 1, 5'd31, 1, 0, 0, 0, O_LU);
    tbl[13] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, O_FRZ);
    tbl[14] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, O_RED);
    tbl[15] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RUN);

    drive(tbl[0]);
    #12;
    chk("reset_outputs", 32'(obs()), 32'(O_RUN));
    chk("reset_err", 32'(hz.err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_err", i), 32'(hz.err_o), 32'd0);
      step();
    end

    // dmem wait: three frozen cycles, released on the fourth
    drive(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_FRZ));
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("memwait_c%0d", c), 32'(obs()), 32'(O_FRZ));
      step();
    end
    hz.dmem_ready_i = 1'b1;
    #2;
    chk("memwait_release", 32'(obs()), 32'(O_RUN));
    step();
    drive(tbl[0]);
    #2;
    chk("memwait_back_run", 32'(obs()), 32'(O_RUN));
    chk("memwait_no_err", 32'(hz.err_o), 32'd0);
    step();

    // timeout: err visible after the 4th wait cycle, sticky
    hz.q4_mem_req_i = 1'b1;
    hz.dmem_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk($sformatf("tmo_c%0d", c), 32'(obs()), 32'(O_FRZ));
      chk($sformatf("tmo_err_c%0d", c), 32'(hz.err_o), (c >= 4) ? 32'd1 : 32'd0);
      step();
    end
    hz.dmem_ready_i = 1'b1;
    #2;
    chk("tmo_release", 32'(obs()), 32'(O_RUN));
    step();
    chk("tmo_sticky", 32'(hz.err_o), 32'd1);
    hz.dmem_ready_i = 1'b0;
    #2;
    chk("tmo_refreeze", 32'(obs()), 32'(O_FRZ));
    step();
    // reset while in MEM_WAIT with inputs idle
    drive(tbl[0]);
    #2;
    chk("tmo_wait_idle", 32'(obs()), 32'(O_FRZ));
    rst_n = 1'b0;
    #1;
    chk("rst_clears_err", 32'(hz.err_o), 32'd0);
    chk("rst_to_run", 32'(obs()), 32'(O_RUN));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // two load-use stalls and one redirect
    drive(tbl[1]);
    step();
    drive(tbl[3]);
    step();
    drive(tbl[7]);
    step();
    drive(tbl[0]);
    #2;
    chk("perf_seq_run", 32'(obs()), 32'(O_RUN));
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd2);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
